// File: rtl/alu_cmd_sequencer.sv
// Command stage ahead of the synchronous ALU: gathers A, B, OP, issues one ALU enable, returns the result.
// Optional opcode/divide-by-zero screening is compiled in with `define ALU_CMD_CHECK_EN.
module alu_cmd_sequencer #(
    parameter int Width   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Width-1:0]   in_data,
    output logic [Width-1:0]   a,
    output logic [Width-1:0]   b,
    output logic [Width-1:0]   op,
    output logic               alu_en,
    input  logic [2*Width-1:0] alu_out,
    input  logic               cout_in,
    input  logic               borrow_in,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*Width-1:0] res_data,
    output logic [1:0]         res_flags,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {S_A, S_B, S_OP, S_ISSUE, S_WAIT, S_RES} state_t;

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          wait_armed;
    logic          xfer;

    assign in_ready = (state == S_A) || (state == S_B) || (state == S_OP);
    assign xfer     = in_valid && in_ready;

`ifdef ALU_CMD_CHECK_EN
    logic reject;
    logic err_q;

    // b is already registered when the opcode arrives, so the zero-divisor test can use it directly
    assign reject = (in_data > Width'(9)) || ((in_data == Width'(3)) && (b == '0));
    assign err    = err_q;
`else
    assign err = 1'b0;
`endif

    // The first S_WAIT cycle only arms the countdown, giving the ALU its latency plus one settling cycle
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state      <= S_A;
            a          <= '0;
            b          <= '0;
            op         <= '0;
            alu_en     <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_flags  <= 2'b00;
            busy       <= 1'b0;
            wait_cnt   <= '0;
            wait_armed <= 1'b0;
`ifdef ALU_CMD_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            alu_en <= 1'b0;
`ifdef ALU_CMD_CHECK_EN
            err_q  <= 1'b0;
`endif
            case (state)
                S_A: begin
                    if (xfer) begin
                        a     <= in_data;
                        busy  <= 1'b1;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (xfer) begin
                        b     <= in_data;
                        state <= S_OP;
                    end
                end
                S_OP: begin
                    if (xfer) begin
                        op <= in_data;
`ifdef ALU_CMD_CHECK_EN
                        if (reject) begin
                            err_q <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_A;
                        end else begin
                            alu_en <= 1'b1;
                            state  <= S_ISSUE;
                        end
`else
                        alu_en <= 1'b1;
                        state  <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    wait_armed <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (!wait_armed) begin
                        wait_cnt   <= CW'(ALU_LAT - 1);
                        wait_armed <= 1'b1;
                    end else if (wait_cnt == '0) begin
                        res_data   <= alu_out;
                        res_flags  <= {borrow_in, cout_in};
                        res_valid  <= 1'b1;
                        wait_armed <= 1'b0;
                        state      <= S_RES;
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                S_RES: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_A;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_A;
                end
            endcase
        end
    end

endmodule
